uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single UARTInterface transmitter between NUM_REQ byte-stream requesters, for example angle report, mic level report and debug.
- Arbitration is packet-level round-robin. A grant is held from a packet's first byte through the byte flagged last.
- Sequences UARTInterface through its data_rdy/tx_busy handshake, one byte at a time.
- Sits between the report generators and uart0 in ChipInterface, replacing the free-running data_rdy_uart logic.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- START_TIMEOUT, 16, cycles to wait for tx_busy to rise after the data_rdy pulse before re-issuing the byte.
- GAP_TIMEOUT, 100_000, idle cycles tolerated mid-packet (req_valid low on the granted port) before the grant is force-released.

Ports:
- clock  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its packet.
- req_ready  out  NUM_REQ  one-cycle pulse: the current byte was taken by the UART; requester advances.
- grant  out  NUM_REQ  one-hot owner of the UART; all zero when free.
- uart_data  out  8  byte to UARTInterface.data.
- uart_data_rdy  out  1  one-cycle start pulse to UARTInterface.data_rdy.
- tx_busy  in  1  from UARTInterface.tx_busy.
- gap_abort  out  1  one-cycle pulse when a packet is force-released by GAP_TIMEOUT.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE, grant=0, req_ready=0, uart_data=0, uart_data_rdy=0, gap_abort=0, rr_ptr=0, all counters 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE:
  - If any req_valid=1 and tx_busy=0, grant the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch that requester's req_data into uart_data; go to ISSUE.
  - If tx_busy=1, stay in IDLE.
- ISSUE: uart_data_rdy=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - On tx_busy=1: pulse req_ready[grant] this cycle, latch req_last into last_q, go to WAIT_DONE.
  - If START_TIMEOUT cycles pass with tx_busy=0, return to ISSUE with the same uart_data. No req_ready pulse; retries are unlimited.
- WAIT_DONE: on tx_busy=0, go as follows:
  - last_q=1: release grant to 0, set rr_ptr = granted index + 1 (mod NUM_REQ), go to IDLE.
  - last_q=0: go to HOLD.
- HOLD (grant kept):
  - If req_valid[grant]=1, latch the byte into uart_data and go to ISSUE.
  - Otherwise increment the gap counter. When it reaches GAP_TIMEOUT, pulse gap_abort, release grant, advance rr_ptr as above, go to IDLE.
  - Valid on other ports is ignored while in HOLD.
- Minimum per-byte overhead: 2 cycles (latch, ISSUE) plus the UART frame time.
- uart_data is stable from the ISSUE cycle until tx_busy falls.
- Simultaneous requests: round-robin order only; no fixed priority.
- A single-byte packet (req_last=1 on the first byte) releases after one byte.
- req_valid dropping while in WAIT_BUSY/WAIT_DONE has no effect; the byte is already committed.
- Reset mid-packet: the grant is dropped immediately. The UART may finish its current frame; the first post-reset grant waits for tx_busy=0.
- NUM_REQ=1: rr_ptr stays 0.

Test Plan:
- Single packet: port 0 sends 3 bytes 0xA5, 0x12, 0x7E (last on 0x7E).
  - Expect 3 uart_data_rdy pulses with those bytes in order and 3 req_ready[0] pulses.
  - grant=001 throughout; grant=000 after the third byte's tx_busy falls.
- Contention: ports 0, 1, 2 all valid with 2-byte packets, rr_ptr=0.
  - Expect packet order 0, 1, 2 with no interleaving.
  - Re-raise all three: order continues 0, 1, 2 with rr_ptr back at 0.
- Round-robin fairness: port 0 continuously valid; port 2 raises valid mid-packet of port 0.
  - After port 0's last byte, port 2 is granted before port 0 again.
- Start timeout: the bench model holds tx_busy=0 for 20 cycles after the first data_rdy.
  - Expect a second data_rdy pulse 17 cycles after the first, with the same byte and no req_ready.
- Gap abort: GAP_TIMEOUT=50; port 1 sends a non-last byte then drops valid.
  - Expect gap_abort 50 cycles after entering HOLD, grant=000, and port 2 (valid) granted next.
- Async reset: assert reset=0 during WAIT_DONE.
  - All outputs go to 0 without waiting for a clock edge.
  - After release with tx_busy still 1, no data_rdy until tx_busy=0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Packet-level round-robin scheduler that shares one UART transmitter between
// NUM_REQ byte-stream requesters using the data_rdy / tx_busy handshake.

module uart_tx_sched_lane (
  input  logic       sel,
  input  logic       valid,
  input  logic [7:0] data,
  input  logic       last,
  input  logic       take,
  output logic       ready,
  output logic       vld_m,
  output logic [7:0] data_m,
  output logic       last_m
);
  // Masked lane outputs are OR-reduced in the top, so unselected lanes drive 0.
  assign ready  = sel & take;
  assign vld_m  = sel & valid;
  assign data_m = sel ? data : 8'h00;
  assign last_m = sel & last;
endmodule

module uart_tx_scheduler #(
  parameter int NUM_REQ       = 3,
  parameter int START_TIMEOUT = 16,
  parameter int GAP_TIMEOUT   = 100_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      grant,
  output logic [7:0]              uart_data,
  output logic                    uart_data_rdy,
  input  logic                    tx_busy,
  output logic                    gap_abort
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t                    state, state_nxt;
  logic [IW-1:0]             gnt_idx, gnt_idx_nxt, rr_ptr, rr_ptr_nxt, ptr_inc, pick_idx;
  logic [NUM_REQ-1:0]        grant_nxt, pick_oh, sel;
  logic                      pick_vld;
  logic [7:0]                uart_data_nxt;
  logic                      last_q, last_nxt;
  logic [TW-1:0]             to_cnt, to_cnt_nxt;
  logic [GW-1:0]             gap_cnt, gap_cnt_nxt;
  logic                      abort_nxt;
  logic                      take;
  logic [NUM_REQ-1:0]        vld_m, last_m;
  logic [NUM_REQ-1:0][7:0]   data_m;
  logic                      sel_vld, sel_last;
  logic [7:0]                sel_data;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && req_valid[j[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = j[IW-1:0];
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = pick_vld;
  end

  // While free the lanes follow the arbiter pick; once granted they follow grant.
  assign sel     = (state == IDLE) ? pick_oh : grant;
  assign take    = (state == WAIT_BUSY) && tx_busy;
  assign ptr_inc = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    uart_tx_sched_lane u_lane (
      .sel    (sel[i]),
      .valid  (req_valid[i]),
      .data   (req_data[i]),
      .last   (req_last[i]),
      .take   (take),
      .ready  (req_ready[i]),
      .vld_m  (vld_m[i]),
      .data_m (data_m[i]),
      .last_m (last_m[i])
    );
  end

  always_comb begin
    sel_vld  = |vld_m;
    sel_last = |last_m;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) sel_data = sel_data | data_m[i];
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    gnt_idx_nxt   = gnt_idx;
    rr_ptr_nxt    = rr_ptr;
    uart_data_nxt = uart_data;
    last_nxt      = last_q;
    to_cnt_nxt    = to_cnt;
    gap_cnt_nxt   = gap_cnt;
    abort_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && !tx_busy) begin
          grant_nxt     = pick_oh;
          gnt_idx_nxt   = pick_idx;
          uart_data_nxt = sel_data;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        to_cnt_nxt = '0;
        state_nxt  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          last_nxt  = sel_last;
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TW'(START_TIMEOUT - 1)) begin
          state_nxt = ISSUE;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_nxt  = '0;
            rr_ptr_nxt = ptr_inc;
            state_nxt  = IDLE;
          end else begin
            gap_cnt_nxt = '0;
            state_nxt   = HOLD;
          end
        end
      end
      HOLD: begin
        if (sel_vld) begin
          uart_data_nxt = sel_data;
          state_nxt     = ISSUE;
        end else if (gap_cnt == GW'(GAP_TIMEOUT - 1)) begin
          abort_nxt  = 1'b1;
          grant_nxt  = '0;
          rr_ptr_nxt = ptr_inc;
          state_nxt  = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // uart_data_rdy is registered off the next state so it is high exactly in ISSUE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      gnt_idx       <= '0;
      rr_ptr        <= '0;
      uart_data     <= '0;
      uart_data_rdy <= 1'b0;
      last_q        <= 1'b0;
      to_cnt        <= '0;
      gap_cnt       <= '0;
      gap_abort     <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      gnt_idx       <= gnt_idx_nxt;
      rr_ptr        <= rr_ptr_nxt;
      uart_data     <= uart_data_nxt;
      uart_data_rdy <= (state_nxt == ISSUE);
      last_q        <= last_nxt;
      to_cnt        <= to_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
      gap_abort     <= abort_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: requester queues and a UART model drive
// the DUT; a packet-level round-robin model predicts the transmitted byte stream.

module tb_uart_tx_scheduler;
  localparam int N     = 3;
  localparam int ST    = 16;
  localparam int GT    = 50;
  localparam int DEPTH = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req_valid, req_last, req_ready, grant;
  logic [N-1:0][7:0] req_data;
  logic [7:0]        uart_data;
  logic              uart_data_rdy, tx_busy, gap_abort;

  uart_tx_scheduler #(.NUM_REQ(N), .START_TIMEOUT(ST), .GAP_TIMEOUT(GT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .uart_data(uart_data),
    .uart_data_rdy(uart_data_rdy), .tx_busy(tx_busy), .gap_abort(gap_abort)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           port;
    logic [7:0]   data;
    logic         last;
    logic [N-1:0] gnt;
    int           cyc;
  } ent_t;

  int         checks = 0, errors = 0;
  ent_t       exp_q[$], obs_q[$];
  logic [8:0] mem [N][DEPTH];
  int         hd[N], tl[N];
  logic [N-1:0] en = '1, pend = '0;
  int         m_ptr = 0;
  int         cyc = 0, n_rdy = 0, n_acc = 0, n_abort = 0;
  int         rdy_cyc[$];
  logic [7:0] rdy_dat[$];
  logic [7:0] rdy_byte = 8'h00;
  logic [N-1:0] abort_gnt = '0;
  int         fall_cyc = 0, abort_cyc = 0;
  int         busy_left = 0, ignore_n = 0, frame_fix = 0;

  // Requesters, UART model and acceptance monitor, all stepped on the falling edge.
  initial begin
    ent_t e;
    int   p;
    tx_busy = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    forever begin
      @(negedge clock);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) hd[i]++;
        req_valid[i] = en[i] && (hd[i] < tl[i]);
        req_data[i]  = (hd[i] < tl[i]) ? mem[i][hd[i]][7:0] : 8'h00;
        req_last[i]  = (hd[i] < tl[i]) && mem[i][hd[i]][8];
      end
      pend = '0;
      if (uart_data_rdy) begin
        n_rdy++; rdy_byte = uart_data; rdy_cyc.push_back(cyc); rdy_dat.push_back(uart_data);
      end
      if (gap_abort) begin n_abort++; abort_cyc = cyc; abort_gnt = grant; end
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin tx_busy = 1'b0; fall_cyc = cyc; end
      end else if (uart_data_rdy) begin
        if (ignore_n > 0) ignore_n--;
        else begin
          tx_busy = 1'b1;
          busy_left = (frame_fix > 0) ? frame_fix : int'($urandom_range(3, 10));
        end
      end
      #1;
      if (req_ready != '0) begin
        p = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) p = i;
        e.port = p; e.data = rdy_byte; e.last = req_last[p]; e.gnt = grant; e.cyc = cyc;
        obs_q.push_back(e);
        pend = req_ready;
        n_acc++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic ent_t mk(input int p, input logic [7:0] d, input logic l);
    ent_t e;
    e.port = p; e.data = d; e.last = l; e.gnt = '0; e.gnt[p] = 1'b1; e.cyc = 0;
    return e;
  endfunction

  task automatic push_byte(input int p, input logic [7:0] d, input logic l);
    mem[p][tl[p]] = {l, d};
    tl[p]++;
  endtask

  task automatic push_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) push_byte(p, 8'($urandom), b == len - 1);
  endtask

  // Reference: whole packets in round-robin order over everything queued now.
  function automatic void rr_model();
    int h[N];
    int p;
    logic [8:0] w;
    logic done;
    done = 1'b0;
    for (int i = 0; i < N; i++) h[i] = hd[i];
    for (int it = 0; it < 1000 && !done; it++) begin
      p = -1;
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (p < 0 && h[j] < tl[j]) p = j;
      end
      if (p < 0) done = 1'b1;
      else begin
        w = 9'h000;
        while (!w[8] && h[p] < tl[p]) begin
          w = mem[p][h[p]]; h[p]++;
          exp_q.push_back(mk(p, w[7:0], w[8]));
        end
        m_ptr = (p + 1) % N;
      end
    end
  endfunction

  function automatic logic all_empty();
    logic r = 1'b1;
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) r = 1'b0;
    return r;
  endfunction

  task automatic flush();
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    en = '1; exp_q.delete(); obs_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    @(negedge clock); #2;
    while (k < budget && !(all_empty() && grant == '0 && !tx_busy && pend == '0)) begin
      @(negedge clock); #2; k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s_idle_timeout: grant=%b tx_busy=%b still busy after %0d cycles", name, grant, tx_busy, budget);
    end
  endtask

  task automatic wait_acc(input string name, input int a0, input int budget);
    int k = 0;
    while (k < budget && n_acc <= a0) begin @(negedge clock); #2; k++; end
    checks++;
    if (k >= budget) begin errors++; $display("FAIL %s_acc_timeout: no req_ready in %0d cycles", name, budget); end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1; m_ptr = 0;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL reset_uart_data: got %h want 00", uart_data); end
    checks++; if (uart_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_data_rdy: got %b want 0", uart_data_rdy); end
    checks++; if (gap_abort !== 1'b0) begin errors++; $display("FAIL reset_gap_abort: got %b want 0", gap_abort); end
    reset = 1'b1; m_ptr = 0;
    #2;
  endtask

  task automatic test_single_packet();
    int r0;
    flush();
    push_byte(0, 8'hA5, 1'b0); push_byte(0, 8'h12, 1'b0); push_byte(0, 8'h7E, 1'b1);
    rr_model();
    r0 = n_rdy;
    wait_idle("single", 300);
    checks++; if (n_rdy - r0 != 3) begin errors++; $display("FAIL single_rdy_pulses: got %0d want 3", n_rdy - r0); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL single_ready_pulses: got %0d want 3", obs_q.size()); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL single_release: got grant %b want 000", grant); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t o, x;
      o = obs_q.pop_front(); x = exp_q.pop_front();
      checks++;
      if (o.port != x.port || o.data !== x.data || o.last !== x.last || o.gnt !== x.gnt) begin
        errors++;
        $display("FAIL single_byte: got p%0d %h last=%b gnt=%b want p%0d %h last=%b gnt=%b",
                 o.port, o.data, o.last, o.gnt, x.port, x.data, x.last, x.gnt);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      flush();
      for (int p = 0; p < N; p++) push_pkt(p, 2);
      rr_model();
      wait_idle("contention", 500);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL contention_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        ent_t o, x;
        o = obs_q.pop_front(); x = exp_q.pop_front();
        checks++;
        if (o.port != x.port || o.data !== x.data || o.last !== x.last || o.gnt !== x.gnt) begin
          errors++;
          $display("FAIL contention_byte r%0d: got p%0d %h last=%b want p%0d %h last=%b",
                   round, o.port, o.data, o.last, x.port, x.data, x.last);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int a0;
    flush();
    for (int k = 0; k < 3; k++) push_pkt(0, 3);
    push_pkt(2, 2);
    en[2] = 1'b0;
    rr_model();
    a0 = n_acc;
    wait_acc("fairness", a0, 100);
    en[2] = 1'b1;
    wait_idle("fairness", 1000);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fairness_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t o, x;
      o = obs_q.pop_front(); x = exp_q.pop_front();
      checks++;
      if (o.port != x.port || o.data !== x.data || o.last !== x.last) begin
        errors++;
        $display("FAIL fairness_order: got p%0d %h last=%b want p%0d %h last=%b",
                 o.port, o.data, o.last, x.port, x.data, x.last);
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      flush();
      for (int p = 0; p < N; p++) begin
        int np = int'($urandom_range(0, 3));
        for (int k = 0; k < np; k++) push_pkt(p, int'($urandom_range(1, 4)));
      end
      rr_model();
      wait_idle("random", 3000);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL random_count r%0d: got %0d bytes want %0d", round, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        ent_t o, x;
        o = obs_q.pop_front(); x = exp_q.pop_front();
        checks++;
        if (o.port != x.port || o.data !== x.data || o.last !== x.last || o.gnt !== x.gnt) begin
          errors++;
          $display("FAIL random_byte r%0d: got p%0d %h last=%b gnt=%b want p%0d %h last=%b gnt=%b",
                   round, o.port, o.data, o.last, o.gnt, x.port, x.data, x.last, x.gnt);
        end
      end
    end
  endtask

  task automatic test_start_timeout();
    int r0;
    ent_t o, x;
    flush();
    push_pkt(1, 1);
    rr_model();
    x = exp_q.pop_front();
    r0 = rdy_cyc.size();
    ignore_n = 1;
    wait_idle("timeout", 300);
    checks++;
    if (rdy_cyc.size() - r0 != 2) begin
      errors++; $display("FAIL timeout_pulses: got %0d data_rdy pulses want 2", rdy_cyc.size() - r0);
    end else begin
      checks++;
      if (rdy_cyc[r0+1] - rdy_cyc[r0] != ST + 1) begin
        errors++; $display("FAIL timeout_spacing: got %0d cycles want %0d", rdy_cyc[r0+1] - rdy_cyc[r0], ST + 1);
      end
      checks++;
      if (rdy_dat[r0] !== x.data || rdy_dat[r0+1] !== x.data) begin
        errors++; $display("FAIL timeout_data: got %h/%h want %h", rdy_dat[r0], rdy_dat[r0+1], x.data);
      end
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL timeout_ready_count: got %0d req_ready pulses want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if (o.port != 1 || rdy_cyc.size() < r0 + 2 || o.cyc <= rdy_cyc[rdy_cyc.size()-1]) begin
        errors++; $display("FAIL timeout_ready_when: got port %0d at cycle %0d, want port 1 after the retry", o.port, o.cyc);
      end
    end
    checks++; if (grant !== '0) begin errors++; $display("FAIL timeout_release: got grant %b want 000", grant); end
  endtask

  task automatic test_gap_abort();
    int a0, r1, b0, k;
    logic [7:0] d1, c0, c1;
    do_reset();
    flush();
    d1 = 8'($urandom); c0 = 8'($urandom); c1 = 8'($urandom);
    push_byte(1, d1, 1'b0); push_byte(1, 8'($urandom), 1'b1);
    push_byte(2, c0, 1'b0); push_byte(2, c1, 1'b1);
    exp_q.push_back(mk(1, d1, 1'b0)); exp_q.push_back(mk(2, c0, 1'b0)); exp_q.push_back(mk(2, c1, 1'b1));
    a0 = n_acc; b0 = n_abort;
    wait_acc("gap", a0, 100);
    en[1] = 1'b0;
    r1 = n_rdy;
    k = 0;
    while (k < 200 && n_abort == b0) begin @(negedge clock); #2; k++; end
    checks++;
    if (n_abort == b0) begin errors++; $display("FAIL gap_abort_missing: no gap_abort within 200 cycles"); end
    else begin
      checks++;
      if (abort_cyc - fall_cyc != GT + 1) begin
        errors++; $display("FAIL gap_abort_delay: got %0d cycles after HOLD entry want %0d", abort_cyc - fall_cyc - 1, GT);
      end
      checks++; if (abort_gnt !== '0) begin errors++; $display("FAIL gap_abort_grant: got %b want 000", abort_gnt); end
      checks++; if (n_rdy != r1) begin errors++; $display("FAIL gap_hold_ignores: got %0d issues during HOLD want 0", n_rdy - r1); end
    end
    hd[1] = tl[1];
    en[1] = 1'b1;
    wait_idle("gap", 300);
    m_ptr = 0;
    checks++; if (n_abort - b0 != 1) begin errors++; $display("FAIL gap_abort_pulses: got %0d want 1", n_abort - b0); end
    checks++;
    if (obs_q.size() != 3) begin errors++; $display("FAIL gap_count: got %0d bytes want 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ent_t o, x;
      o = obs_q.pop_front(); x = exp_q.pop_front();
      checks++;
      if (o.port != x.port || o.data !== x.data || o.last !== x.last) begin
        errors++;
        $display("FAIL gap_byte: got p%0d %h last=%b want p%0d %h last=%b", o.port, o.data, o.last, x.port, x.data, x.last);
      end
    end
  endtask

  task automatic test_async_reset();
    int a0, r0, k;
    logic [7:0] b1;
    flush();
    push_pkt(0, 3);
    b1 = mem[0][1][7:0];
    frame_fix = 30;
    a0 = n_acc;
    wait_acc("areset", a0, 100);
    @(posedge clock); #2;
    reset = 1'b0;
    frame_fix = 0;
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL areset_grant: got %b want 0", grant); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL areset_req_ready: got %b want 0", req_ready); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL areset_uart_data: got %h want 00", uart_data); end
    checks++; if (uart_data_rdy !== 1'b0) begin errors++; $display("FAIL areset_data_rdy: got %b want 0", uart_data_rdy); end
    checks++; if (gap_abort !== 1'b0) begin errors++; $display("FAIL areset_gap_abort: got %b want 0", gap_abort); end
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b1; m_ptr = 0;
    r0 = n_rdy;
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL areset_busy_model: got tx_busy %b want 1", tx_busy); end
    k = 0;
    while (k < 100 && tx_busy) begin @(negedge clock); #2; k++; end
    checks++; if (n_rdy != r0) begin errors++; $display("FAIL areset_early_issue: got %0d data_rdy while busy want 0", n_rdy - r0); end
    k = 0;
    while (k < 20 && n_rdy == r0) begin @(negedge clock); #2; k++; end
    checks++;
    if (n_rdy == r0 || rdy_byte !== b1) begin
      errors++; $display("FAIL areset_resume: got %0d issues byte %h want 1 issue byte %h", n_rdy - r0, rdy_byte, b1);
    end
    wait_idle("areset", 300);
    flush();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_fairness();
    test_random();
    test_start_timeout();
    test_gap_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
